// File: rtl/snap_ram_arbiter.sv
// snap_ram_arbiter
//   Shares the single SDRAM write port between the snapshot loader (port A)
//   and the tape/aux loader (port B). Each port queues single-cycle write
//   pulses in its own FIFO; a round-robin arbiter issues the queued entries
//   to RAM over a level req/ack handshake.
//
// Ports
//   clk_sys_i            system clock, all logic on posedge
//   reset_i              asynchronous active-high reset
//   a_wr_i/a_addr_i/a_data_i, b_wr_i/b_addr_i/b_data_i
//                        per-port write pulse with address and data
//   a_ready_o/b_ready_o  port may issue another write next cycle
//   a_ovf_o/b_ovf_o      sticky flag: a write was dropped while the FIFO was full
//   ram_hold_i           CPU owns RAM, no new request may start
//   ram_we_o             write request, held high until ram_ack_i
//   ram_addr_o/ram_din_o request address/data, stable while ram_we_o is high
//   ram_ack_i            single-cycle completion of the current request
//   idle_o               both FIFOs empty and no request outstanding
//   grant_o              source of the current/last request (0=A, 1=B)
module snap_ram_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 25
) (
    input  logic          clk_sys_i,
    input  logic          reset_i,
    input  logic          a_wr_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [7:0]    a_data_i,
    output logic          a_ready_o,
    output logic          a_ovf_o,
    input  logic          b_wr_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [7:0]    b_data_i,
    output logic          b_ready_o,
    output logic          b_ovf_o,
    input  logic          ram_hold_i,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [7:0]    ram_din_o,
    input  logic          ram_ack_i,
    output logic          idle_o,
    output logic          grant_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = AW + 8;

    typedef enum logic {StIdle, StWait} state_e;

    logic [1:0]               wr;
    logic [1:0][EW-1:0]       wentry;
    logic [1:0][EW-1:0]       head;
    logic [1:0]               nonempty;
    logic [1:0]               ready;
    logic [1:0]               ovf;
    logic [1:0]               pop;

    assign wr        = {b_wr_i, a_wr_i};
    assign wentry[0] = {a_data_i, a_addr_i};
    assign wentry[1] = {b_data_i, b_addr_i};

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [EW-1:0] mem_q [DEPTH];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] count_q;
        logic          ovf_q;
        logic          push;

        // A write against a full FIFO is dropped even if a pop frees a slot
        // in the same cycle; the loader is expected to honour ready.
        assign push        = wr[p] && (count_q < CW'(DEPTH));
        assign head[p]     = mem_q[rptr_q];
        assign nonempty[p] = (count_q != '0);
        assign ready[p]    = (count_q <= CW'(DEPTH - 2));
        assign ovf[p]      = ovf_q;

        always_ff @(posedge clk_sys_i) begin
            if (push) begin
                mem_q[wptr_q] <= wentry[p];
            end
        end

        always_ff @(posedge clk_sys_i or posedge reset_i) begin
            if (reset_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (push) begin
                    wptr_q <= wptr_q + PW'(1);
                end
                if (pop[p]) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop[p]);
                if (wr[p] && !push) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          grant_q, grant_d;
    logic          sel;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        grant_d = grant_q;
        pop     = '0;
        sel     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!ram_hold_i && (nonempty != '0)) begin
                    // Round-robin only matters when both ports have work.
                    sel      = (nonempty == 2'b11) ? ~grant_q : nonempty[1];
                    pop[sel] = 1'b1;
                    addr_d   = head[sel][AW-1:0];
                    din_d    = head[sel][EW-1:AW];
                    we_d     = 1'b1;
                    grant_d  = sel;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (ram_ack_i) begin
                    we_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                we_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            grant_q <= grant_d;
        end
    end

    assign ram_we_o   = we_q;
    assign ram_addr_o = addr_q;
    assign ram_din_o  = din_q;
    assign grant_o    = grant_q;
    assign idle_o     = (state_q == StIdle) && (nonempty == '0);
    assign a_ready_o  = ready[0];
    assign b_ready_o  = ready[1];
    assign a_ovf_o    = ovf[0];
    assign b_ovf_o    = ovf[1];

endmodule

// File: tb/tb_snap_ram_arbiter.sv
// Bench for snap_ram_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_snap_ram_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 25;

    typedef logic [AW+7:0] ent_t;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          a_wr = 1'b0, b_wr = 1'b0, ram_hold = 1'b0, ram_ack = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [7:0]    a_data = '0, b_data = '0;
    logic          a_ready, a_ovf, b_ready, b_ovf, ram_we, idle, grant;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;

    snap_ram_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_sys_i (clk_sys),
        .reset_i   (reset),
        .a_wr_i    (a_wr),
        .a_addr_i  (a_addr),
        .a_data_i  (a_data),
        .a_ready_o (a_ready),
        .a_ovf_o   (a_ovf),
        .b_wr_i    (b_wr),
        .b_addr_i  (b_addr),
        .b_data_i  (b_data),
        .b_ready_o (b_ready),
        .b_ovf_o   (b_ovf),
        .ram_hold_i(ram_hold),
        .ram_we_o  (ram_we),
        .ram_addr_o(ram_addr),
        .ram_din_o (ram_din),
        .ram_ack_i (ram_ack),
        .idle_o    (idle),
        .grant_o   (grant)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // Reference model: per-port queues plus the one outstanding request.
    ent_t qa[$];
    ent_t qb[$];
    bit   m_busy, m_grant, m_ovf_a, m_ovf_b;
    ent_t m_cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_busy  = 1'b0;
        m_grant = 1'b0;
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;
        m_cur   = '0;
    endtask

    task automatic check_all();
        chk("ram_we", 64'(ram_we), 64'(m_busy));
        if (m_busy) begin
            chk("ram_addr", 64'(ram_addr), 64'(m_cur[AW-1:0]));
            chk("ram_din", 64'(ram_din), 64'(m_cur[AW+7:AW]));
        end
        chk("grant", 64'(grant), 64'(m_grant));
        chk("idle", 64'(idle), 64'(!m_busy && qa.size() == 0 && qb.size() == 0));
        chk("a_ready", 64'(a_ready), 64'(qa.size() <= DEPTH - 2));
        chk("b_ready", 64'(b_ready), 64'(qb.size() <= DEPTH - 2));
        chk("a_ovf", 64'(a_ovf), 64'(m_ovf_a));
        chk("b_ovf", 64'(b_ovf), 64'(m_ovf_b));
    endtask

    // Advance one clock with the currently driven inputs, update the model,
    // then check all outputs shortly after the edge.
    task automatic tick();
        logic wa, wb, hold, ack;
        ent_t ea, eb;
        int   ca, cb;
        bit   src;
        wa = a_wr; wb = b_wr; hold = ram_hold; ack = ram_ack;
        ea = {a_data, a_addr};
        eb = {b_data, b_addr};
        @(posedge clk_sys);
        ca = qa.size();
        cb = qb.size();
        if (!m_busy) begin
            if (!hold && (ca > 0 || cb > 0)) begin
                src = (ca > 0 && cb > 0) ? !m_grant : (cb > 0);
                m_cur   = src ? qb.pop_front() : qa.pop_front();
                m_grant = src;
                m_busy  = 1'b1;
            end
        end else if (ack) begin
            m_busy = 1'b0;
        end
        if (wa) begin
            if (ca < DEPTH) qa.push_back(ea);
            else m_ovf_a = 1'b1;
        end
        if (wb) begin
            if (cb < DEPTH) qb.push_back(eb);
            else m_ovf_b = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic quiet();
        a_wr = 1'b0; b_wr = 1'b0; ram_ack = 1'b0; ram_hold = 1'b0;
    endtask

    task automatic push_a(input logic [AW-1:0] ad, input logic [7:0] d);
        a_wr = 1'b1; a_addr = ad; a_data = d;
    endtask

    task automatic push_b(input logic [AW-1:0] ad, input logic [7:0] d);
        b_wr = 1'b1; b_addr = ad; b_data = d;
    endtask

    // Acknowledge every outstanding request until both queues drain.
    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            quiet();
            ram_ack = m_busy;
            tick();
        end
        chk("drain_idle", 64'(idle), 64'(1));
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_we", 64'(ram_we), 64'(0));
        chk("rst_addr", 64'(ram_addr), 64'(0));
        chk("rst_din", 64'(ram_din), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_a_ready", 64'(a_ready), 64'(1));
        chk("rst_b_ready", 64'(b_ready), 64'(1));
        chk("rst_a_ovf", 64'(a_ovf), 64'(0));
        chk("rst_b_ovf", 64'(b_ovf), 64'(0));
        model_reset();
        quiet();
        #3 reset = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        quiet();
        #3;
        do_reset();

        // 1: single A write, ack three cycles into the request.
        push_a(25'h14000, 8'h5A);
        tick();
        quiet();
        tick();
        chk("t1_we_n2", 64'(ram_we), 64'(1));
        chk("t1_addr", 64'(ram_addr), 64'h14000);
        chk("t1_din", 64'(ram_din), 64'h5A);
        tick();
        tick();
        ram_ack = 1'b1;
        tick();
        quiet();
        chk("t1_idle", 64'(idle), 64'(1));

        // 2: burst of six A pulses with no ack; the sixth overflows.
        for (int i = 0; i < 6; i++) begin
            push_a(AW'(32'h100 + i), 8'(8'h10 + i));
            tick();
        end
        quiet();
        chk("t2_ovf", 64'(a_ovf), 64'(1));
        chk("t2_ready", 64'(a_ready), 64'(0));
        drain();

        // 3/4: fill both ports under hold, then release and alternate.
        ram_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_a(AW'(32'h200 + i), 8'(8'hA0 + i));
            push_b(AW'(32'h300 + i), 8'(8'hB0 + i));
            tick();
        end
        quiet();
        ram_hold = 1'b1;
        tick();
        chk("t4_hold_we", 64'(ram_we), 64'(0));
        ram_hold = 1'b0;
        tick();
        chk("t4_release_we", 64'(ram_we), 64'(1));
        // Hold raised while a request is outstanding must not stall it.
        ram_hold = 1'b1;
        tick();
        ram_ack = 1'b1;
        tick();
        chk("t4_wait_done", 64'(ram_we), 64'(0));
        quiet();
        drain();

        // 5: ten sequential writes paced by ready, acked immediately.
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            quiet();
            ram_ack = m_busy;
            if (qa.size() <= DEPTH - 2) begin
                push_a(AW'(n), 8'(8'hC0 + n));
                n++;
            end
            tick();
        end
        chk("t5_all_pushed", 64'(n), 64'(10));
        drain();

        // 6: reset while a request is outstanding, with an overflow latched.
        for (int i = 0; i < 6; i++) begin
            push_b(AW'(32'h400 + i), 8'(i));
            tick();
        end
        quiet();
        tick();
        chk("t6_pre_we", 64'(ram_we), 64'(1));
        chk("t6_pre_ovf", 64'(b_ovf), 64'(1));
        do_reset();

        // Random traffic in phases of increasing write pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                quiet();
                if ($urandom_range(0, 7) < ph * 2 + 1) push_a(AW'($urandom), 8'($urandom));
                if ($urandom_range(0, 7) < ph * 2 + 1) push_b(AW'($urandom), 8'($urandom));
                ram_hold = ($urandom_range(0, 4) == 0);
                ram_ack  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                tick();
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
